apb4_responder: RTL



---
 rtl/apb4_responder.sv | 130 +++++++++++++
 1 files changed

// File: rtl/apb4_responder.sv
// APB4 completer: word-addressed byte-strobed storage with programmable wait
// states, and PSLVERR for out-of-range or unprivileged accesses.
module apb4_responder #(
   parameter int PADDR_SIZE = 10,
   parameter int PDATA_SIZE = 32,
   parameter int DEPTH      = 64,
   parameter int PRIV_BASE  = 48
) (
   input  logic                    PCLK,
   input  logic                    PRESET,
   input  logic                    PSEL,
   input  logic                    PENABLE,
   input  logic [2:0]              PPROT,
   input  logic                    PWRITE,
   input  logic [PDATA_SIZE/8-1:0] PSTRB,
   input  logic [PADDR_SIZE-1:0]   PADDR,
   input  logic [PDATA_SIZE-1:0]   PWDATA,
   input  logic [3:0]              WAITS,
   output logic [PDATA_SIZE-1:0]   PRDATA,
   output logic                    PREADY,
   output logic                    PSLVERR
);

   localparam int BYTES    = PDATA_SIZE / 8;
   localparam int ADDR_LSB = $clog2(BYTES);
   localparam int IDX_W    = PADDR_SIZE - ADDR_LSB;
   localparam int MEM_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

   state_t            state;
   logic [3:0]        count;
   logic [MEM_AW-1:0] idx_q;
   logic              write_q;
   logic [BYTES-1:0]  strb_q;
   logic              err_q;

   logic [PDATA_SIZE-1:0] mem [DEPTH];

   logic [IDX_W-1:0]  setup_idx;
   logic              setup;
   logic              setup_err;
   logic              from_idle;
   logic              complete;
   logic [MEM_AW-1:0] cur_idx;
   logic              cur_write;
   logic              cur_err;
   logic [BYTES-1:0]  cur_strb;
   logic              mem_we;
   logic              unused_bits;

   assign setup_idx = PADDR[PADDR_SIZE-1:ADDR_LSB];
   assign setup     = PSEL && !PENABLE;
   assign setup_err = (32'(setup_idx) >= 32'(DEPTH)) ||
                      ((32'(setup_idx) >= 32'(PRIV_BASE)) && !PPROT[0]);

   // A zero-wait transfer completes straight from IDLE, so it uses the live
   // setup-phase values instead of the latched copies.
   assign from_idle = (state == ST_IDLE);
   assign complete  = (from_idle && setup && (WAITS == 4'd0)) ||
                      ((state == ST_WAIT) && PSEL && (count == 4'd1));
   assign cur_idx   = from_idle ? setup_idx[MEM_AW-1:0] : idx_q;
   assign cur_write = from_idle ? PWRITE : write_q;
   assign cur_err   = from_idle ? setup_err : err_q;
   assign cur_strb  = from_idle ? PSTRB : strb_q;
   assign mem_we    = complete && !PRESET && cur_write && !cur_err;

   assign unused_bits = ^{PPROT[2:1], PADDR};

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state   <= ST_IDLE;
         count   <= 4'd0;
         idx_q   <= '0;
         write_q <= 1'b0;
         strb_q  <= '0;
         err_q   <= 1'b0;
         PREADY  <= 1'b0;
         PSLVERR <= 1'b0;
         PRDATA  <= '0;
      end else begin
         PREADY  <= complete;
         PSLVERR <= complete && cur_err;
         if (complete && !cur_write)
            PRDATA <= cur_err ? '0 : mem[cur_idx];

         case (state)
            ST_IDLE: begin
               if (setup) begin
                  idx_q   <= setup_idx[MEM_AW-1:0];
                  write_q <= PWRITE;
                  strb_q  <= PSTRB;
                  err_q   <= setup_err;
                  if (WAITS == 4'd0) begin
                     state <= ST_DONE;
                  end else begin
                     count <= WAITS;
                     state <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               // Losing PSEL mid-transfer abandons it without a response.
               if (!PSEL) begin
                  state <= ST_IDLE;
                  count <= 4'd0;
               end else if (count == 4'd1) begin
                  state <= ST_DONE;
                  count <= 4'd0;
               end else begin
                  count <= count - 4'd1;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Storage is deliberately left out of reset so contents survive PRESET.
   always_ff @(posedge PCLK) begin
      if (mem_we) begin
         for (int i = 0; i < BYTES; i++) begin
            if (cur_strb[i])
               mem[cur_idx][8*i +: 8] <= PWDATA[8*i +: 8];
         end
      end
   end

endmodule
